// File: rtl/reg_file_sb.sv
// Parametrised 2R/1W register file with registered, write-bypassed reads, a per-entry
// pending-write scoreboard and a post-reset clear sequencer. Option: REG_FILE_SB_R0_ZERO_EN.
module reg_file_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rn_addr,
   input  logic [ADDR_W-1:0] rm_addr,
   output logic [DATA_W-1:0] rn_data,
   output logic [DATA_W-1:0] rm_data,
   output logic              rn_pend,
   output logic              rm_pend,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              w_en,
   input  logic              lock_en,
   input  logic [ADDR_W-1:0] lock_addr,
   output logic              init_busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   localparam logic CLEAR = 1'b0;
   localparam logic RUN   = 1'b1;

`ifdef REG_FILE_SB_R0_ZERO_EN
   localparam bit R0_ZERO = 1'b1;
`else
   localparam bit R0_ZERO = 1'b0;
`endif

   logic              state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;

   logic              run;
   logic              wr_ok, lk_ok;
   logic              rn_zero, rm_zero;
   logic [DATA_W-1:0] rn_data_d, rm_data_d;
   logic              rn_pend_d, rm_pend_d;

   assign run       = (state_q == RUN);
   assign init_busy = ~run;

   // Entry 0 may be hardwired: its writes/locks vanish and its reads are forced to zero.
   assign rn_zero = R0_ZERO && (rn_addr == '0);
   assign rm_zero = R0_ZERO && (rm_addr == '0);
   assign wr_ok   = run && w_en && !(R0_ZERO && (rd_addr == '0));
   assign lk_ok   = run && lock_en && !(R0_ZERO && (lock_addr == '0));

   // Lock is applied after the write-clear so it wins on an address collision.
   always_comb begin
      pend_d = pend_q;
      if (wr_ok) pend_d[rd_addr] = 1'b0;
      if (lk_ok) pend_d[lock_addr] = 1'b1;
   end

   always_comb begin
      rn_data_d = mem[rn_addr];
      rm_data_d = mem[rm_addr];
      if (wr_ok && (rd_addr == rn_addr)) rn_data_d = rd_data;
      if (wr_ok && (rd_addr == rm_addr)) rm_data_d = rd_data;
      if (rn_zero) rn_data_d = '0;
      if (rm_zero) rm_data_d = '0;
      rn_pend_d = run && !rn_zero && pend_d[rn_addr];
      rm_pend_d = run && !rm_zero && pend_d[rm_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         pend_q  <= '0;
         rn_data <= '0;
         rm_data <= '0;
         rn_pend <= 1'b0;
         rm_pend <= 1'b0;
      end else begin
         if (state_q == CLEAR) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (ptr_q == {ADDR_W{1'b1}}) state_q <= RUN;
         end
         pend_q  <= pend_d;
         rn_data <= rn_data_d;
         rm_data <= rm_data_d;
         rn_pend <= rn_pend_d;
         rm_pend <= rm_pend_d;
      end
   end

   // The array itself is never reset; the clear sequencer zeroes it one entry per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[ptr_q] <= '0;
         end else if (wr_ok) begin
            mem[rd_addr] <= rd_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes expected read results, a monitor
// pops and compares them one cycle later. Covers REG_FILE_SB_R0_ZERO_EN when defined.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  rn_addr = '0, rm_addr = '0, rd_addr = '0, lock_addr = '0;
   logic [31:0] rn_data, rm_data, rd_data = '0;
   logic        rn_pend, rm_pend, init_busy;
   logic        w_en = 1'b0, lock_en = 1'b0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .ADDR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .rn_addr   (rn_addr),
      .rm_addr   (rm_addr),
      .rn_data   (rn_data),
      .rm_data   (rm_data),
      .rn_pend   (rn_pend),
      .rm_pend   (rm_pend),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .w_en      (w_en),
      .lock_en   (lock_en),
      .lock_addr (lock_addr),
      .init_busy (init_busy)
   );

   typedef struct {
      logic [31:0] n;
      logic [31:0] m;
      logic        pn;
      logic        pm;
      string       nm;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   busy_cnt = 0;
   logic chk_v = 1'b0;
   logic chk_d = 1'b0;

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   // Drive one cycle of inputs, sampled at the next rising edge.
   task automatic cyc(input logic r, input logic w, input logic [3:0] wa, input logic [31:0] wd,
                      input logic lk, input logic [3:0] la, input logic [3:0] na,
                      input logic [3:0] ma);
      @(posedge clk);
      #1;
      rst = r; w_en = w; rd_addr = wa; rd_data = wd;
      lock_en = lk; lock_addr = la; rn_addr = na; rm_addr = ma;
      chk_v = 1'b0;
   endtask

   task automatic expect_rd(input logic [31:0] n, input logic [31:0] m, input logic pn,
                            input logic pm, input string nm);
      chk_v = 1'b1;
      sb_q.push_back('{n: n, m: m, pn: pn, pm: pm, nm: nm});
   endtask

   task automatic check_reset_outputs(input string nm);
      @(negedge clk);
      check({nm, "_rn_data"}, rn_data, 32'h0);
      check({nm, "_rm_data"}, rm_data, 32'h0);
      check({nm, "_rn_pend"}, 32'(rn_pend), 32'h0);
      check({nm, "_rm_pend"}, 32'(rm_pend), 32'h0);
      check({nm, "_busy"}, 32'(init_busy), 32'h1);
   endtask

   always @(posedge clk) chk_d <= chk_v;

   always @(negedge clk) begin
      if (init_busy === 1'b1) busy_cnt++;
      if (chk_d) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got output with empty queue, expected an entry");
         end else begin
            e = sb_q.pop_front();
            check({e.nm, "_rn_data"}, rn_data, e.n);
            check({e.nm, "_rm_data"}, rm_data, e.m);
            check({e.nm, "_rn_pend"}, 32'(rn_pend), 32'(e.pn));
            check({e.nm, "_rm_pend"}, 32'(rm_pend), 32'(e.pm));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Power-up reset with writes and locks held during the whole clear sequence.
      rst = 1'b1; w_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 4'(15 - i), 32'hA5A50000 | 32'(i), 1'b1, 4'(15 - i), 4'd0, 4'd0);
         if (i == 0) begin
            busy_cnt = 0;
            check_reset_outputs("por");
         end
      end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i), 4'(15 - i));
         expect_rd(32'h0, 32'h0, 1'b0, 1'b0, "cleared");
      end
      check("por_busy_cycles", 32'(busy_cnt), 32'd16);

      cyc(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 4'd0);
      expect_rd(32'h0, 32'h0, 1'b0, 1'b0, "wr5_issue");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd0);
      expect_rd(32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "rd_after_wr");
      cyc(1'b0, 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0, 4'd3, 4'd3);
      expect_rd(32'h12345678, 32'h12345678, 1'b0, 1'b0, "bypass_both");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 4'd5, 4'd0);
      expect_rd(32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "lock7_issue");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd3);
      expect_rd(32'h0, 32'h12345678, 1'b1, 1'b0, "pend_after_lock");
      cyc(1'b0, 1'b1, 4'd7, 32'h00000777, 1'b0, 4'd0, 4'd0, 4'd7);
      expect_rd(32'h0, 32'h00000777, 1'b0, 1'b0, "wr_clears_pend_bypass");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd7);
      expect_rd(32'h00000777, 32'h00000777, 1'b0, 1'b0, "pend_cleared");
      cyc(1'b0, 1'b1, 4'd7, 32'h00000888, 1'b1, 4'd7, 4'd7, 4'd5);
      expect_rd(32'h00000888, 32'hDEADBEEF, 1'b1, 1'b0, "lock_wins");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd5, 4'd7);
      expect_rd(32'hDEADBEEF, 32'h00000888, 1'b0, 1'b1, "lock_wins_held");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 4'd9, 4'd9);
      expect_rd(32'h0, 32'h0, 1'b1, 1'b1, "lock_bypass");
      cyc(1'b0, 1'b1, 4'd10, 32'h0000AAAA, 1'b0, 4'd0, 4'd0, 4'd0);

      cyc(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd0, 4'd0);
`ifdef REG_FILE_SB_R0_ZERO_EN
      expect_rd(32'h0, 32'h0, 1'b0, 1'b0, "r0_bypass");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd10);
      expect_rd(32'h0, 32'h0000AAAA, 1'b0, 1'b0, "r0_later");
`else
      expect_rd(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, "r0_bypass");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd10);
      expect_rd(32'hFFFFFFFF, 32'h0000AAAA, 1'b1, 1'b0, "r0_later");
`endif
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd10);
      expect_rd(32'h00000888, 32'h0000AAAA, 1'b1, 1'b0, "pre_reset");

      // Reset from RUN, then a second reset once the clear pointer reaches 9.
      cyc(1'b1, 1'b1, 4'd7, 32'h00001111, 1'b1, 4'd10, 4'd7, 4'd10);
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd10, 4'd7);
      check_reset_outputs("run_rst");
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd10, 4'd7);
      cyc(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd10, 4'd10);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 4'(i), 32'h5A5A5A5A, 1'b0, 4'd0, 4'd10, 4'd10);
         if (i == 0) begin
            busy_cnt = 0;
            check_reset_outputs("mid_clear_rst");
         end
      end
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd7, 4'd10);
      expect_rd(32'h0, 32'h0, 1'b0, 1'b0, "after_reclear");
      cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9, 4'd15);
      expect_rd(32'h0, 32'h0, 1'b0, 1'b0, "pend_reset");
      check("mid_clear_busy_cycles", 32'(busy_cnt), 32'd16);

      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
